mutative_reconfig_ctrl: RTL and testbench

Sequencing controller for the mutative cache's associativity mode (`setup`: direct-mapped, 2-, 4- or 8-way). It accepts a reconfiguration request, stalls new CPU traffic and waits for in-flight misses to drain. It then sweeps every set so the datapath writes back and invalidates all ways and clears that set's PLRU bits, and only then commits the new `setup` value consumed by the tag/data arrays and the PLRU replacement logic.

---
 rtl/mutative_reconfig_ctrl_pkg.sv | 24 ++
 rtl/mutative_reconfig_ctrl.sv | 97 +++++++++
 tb/tb_mutative_reconfig_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mutative_reconfig_ctrl_pkg.sv
// Shared types for the mutative cache: associativity modes, geometry and
// the reconfiguration sequencer's state encoding.
package mutative_types;

    localparam int SET_SIZE     = 16;
    localparam int WAYS         = 8;
    localparam int WAY_IDX_BITS = $clog2(WAYS);
    localparam int SET_IDX_BITS = $clog2(SET_SIZE);

    typedef enum logic [1:0] {
        SETUP_DM = 2'b00,
        SETUP_2W = 2'b01,
        SETUP_4W = 2'b10,
        SETUP_8W = 2'b11
    } setup_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DRAIN  = 2'b01,
        SWEEP  = 2'b10,
        COMMIT = 2'b11
    } reconfig_state_t;

endpackage

// File: rtl/mutative_reconfig_ctrl.sv
// Sequences an associativity change: stall, drain in-flight misses, flush
// every set, then commit the new setup in a single clean transition.
module mutative_reconfig_ctrl
    import mutative_types::*;
#(
    parameter setup_t DEFAULT_SETUP = SETUP_8W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // Handshakes: a transfer happens on the rising edge where valid && ready;
    // valid and its payload hold until then, ready never depends on valid.
    input  logic                    cfg_valid,
    input  logic [1:0]              cfg_setup,
    output logic                    cfg_ready,
    input  logic                    cache_busy,
    output logic                    stall_req,
    output logic                    sweep_valid,
    output logic [SET_IDX_BITS-1:0] sweep_set,
    input  logic                    sweep_ready,
    output logic [1:0]              setup,
    output logic                    reconfig_done,
    output reconfig_state_t         dbg_state
);

    localparam logic [SET_IDX_BITS-1:0] LAST_SET = SET_IDX_BITS'(SET_SIZE - 1);

    reconfig_state_t           state_q, state_d;
    logic [SET_IDX_BITS-1:0]   count_q;
    setup_t                    pending_q;
    setup_t                    setup_q;
    logic                      cfg_hs;

    assign cfg_hs = cfg_valid && cfg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_hs) state_d = (setup_t'(cfg_setup) == setup_q) ? COMMIT : DRAIN;
            DRAIN:   if (!cache_busy) state_d = SWEEP;
            SWEEP:   if (sweep_ready && (count_q == LAST_SET)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            pending_q <= DEFAULT_SETUP;
            setup_q   <= DEFAULT_SETUP;
        end else begin
            if (cfg_hs) pending_q <= setup_t'(cfg_setup);
            if (state_q == DRAIN && !cache_busy) begin
                count_q <= '0;
            end else if (state_q == SWEEP && sweep_ready && count_q != LAST_SET) begin
                count_q <= count_q + 1'b1;
            end
            if (state_q == COMMIT) setup_q <= pending_q;
        end
    end

    // In COMMIT, pending differs from setup only when a sweep preceded it,
    // which is exactly when the front end must stay stalled.
    always_comb begin
        cfg_ready     = 1'b0;
        stall_req     = 1'b0;
        sweep_valid   = 1'b0;
        sweep_set     = '0;
        reconfig_done = 1'b0;
        case (state_q)
            IDLE:   cfg_ready = 1'b1;
            DRAIN:  stall_req = 1'b1;
            SWEEP: begin
                stall_req   = 1'b1;
                sweep_valid = 1'b1;
                sweep_set   = count_q;
            end
            COMMIT: begin
                stall_req     = (pending_q != setup_q);
                reconfig_done = 1'b1;
            end
            default: cfg_ready = 1'b0;
        endcase
    end

    assign setup     = setup_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mutative_reconfig_ctrl.sv
// Directed bench for mutative_reconfig_ctrl: reset, no-op, idle change,
// drain wait, sweep backpressure and reset in the middle of a sweep.
module tb_mutative_reconfig_ctrl;
    import mutative_types::*;

    logic                    clk;
    logic                    rst_n;
    logic                    cfg_valid;
    logic [1:0]              cfg_setup;
    logic                    cfg_ready;
    logic                    cache_busy;
    logic                    stall_req;
    logic                    sweep_valid;
    logic [SET_IDX_BITS-1:0] sweep_set;
    logic                    sweep_ready;
    logic [1:0]              setup;
    logic                    reconfig_done;
    reconfig_state_t         dbg_state;

    int errors = 0;
    int checks = 0;

    mutative_reconfig_ctrl #(.DEFAULT_SETUP(SETUP_8W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_setup    (cfg_setup),
        .cfg_ready    (cfg_ready),
        .cache_busy   (cache_busy),
        .stall_req    (stall_req),
        .sweep_valid  (sweep_valid),
        .sweep_set    (sweep_set),
        .sweep_ready  (sweep_ready),
        .setup        (setup),
        .reconfig_done(reconfig_done),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle and checks outputs before any clock edge.
    task automatic apply_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL %s_cfg_ready got=%b exp=1", tag, cfg_ready); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL %s_stall got=%b exp=0", tag, stall_req); end
        checks++; if (sweep_valid !== 1'b0) begin errors++; $display("FAIL %s_sweep_valid got=%b exp=0", tag, sweep_valid); end
        checks++; if (sweep_set !== 4'd0) begin errors++; $display("FAIL %s_sweep_set got=%0d exp=0", tag, sweep_set); end
        checks++; if (setup !== 2'b11) begin errors++; $display("FAIL %s_setup got=%b exp=11", tag, setup); end
        checks++; if (reconfig_done !== 1'b0) begin errors++; $display("FAIL %s_done got=%b exp=0", tag, reconfig_done); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL %s_state got=%0d exp=IDLE", tag, dbg_state); end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // driver: one-cycle request, leaves the bench at cycle T+1
    task automatic issue(input logic [1:0] mode, input string tag);
        cfg_valid = 1'b1;
        cfg_setup = mode;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL %s_accept got=%b exp=1", tag, cfg_ready); end
        step();
        cfg_valid = 1'b0;
    endtask

    // Entered at the first SWEEP cycle; walks all sets, then COMMIT and IDLE.
    task automatic sweep_and_commit(input int hold_set, input int hold_cycles,
                                    input logic [1:0] old_setup, input logic [1:0] new_setup,
                                    input string tag);
        int set_i = 0;
        int held = 0;
        int cycles = 0;
        while (set_i < SET_SIZE && cycles < 64) begin
            checks++; if (sweep_valid !== 1'b1 || sweep_set !== 4'(set_i) || stall_req !== 1'b1)
                begin errors++; $display("FAIL %s_sweep cyc=%0d got valid=%b set=%0d stall=%b exp valid=1 set=%0d stall=1",
                                         tag, cycles, sweep_valid, sweep_set, stall_req, set_i); end
            if (set_i == hold_set && held < hold_cycles) begin
                sweep_ready = 1'b0;
                held++;
            end else begin
                sweep_ready = 1'b1;
                set_i++;
            end
            step();
            cycles++;
        end
        sweep_ready = 1'b1;
        checks++; if (cycles !== SET_SIZE + hold_cycles) begin errors++; $display("FAIL %s_sweep_len got=%0d exp=%0d", tag, cycles, SET_SIZE + hold_cycles); end
        checks++; if (reconfig_done !== 1'b1 || stall_req !== 1'b1 || sweep_valid !== 1'b0 || setup !== old_setup)
            begin errors++; $display("FAIL %s_commit got done=%b stall=%b valid=%b setup=%b exp done=1 stall=1 valid=0 setup=%b",
                                     tag, reconfig_done, stall_req, sweep_valid, setup, old_setup); end
        step();
        checks++; if (setup !== new_setup || reconfig_done !== 1'b0 || cfg_ready !== 1'b1 || stall_req !== 1'b0)
            begin errors++; $display("FAIL %s_idle got setup=%b done=%b ready=%b stall=%b exp setup=%b done=0 ready=1 stall=0",
                                     tag, setup, reconfig_done, cfg_ready, stall_req, new_setup); end
    endtask

    task automatic test_reset();
        step();
        apply_reset("reset");
    endtask

    task automatic test_noop();
        cfg_valid = 1'b1;
        cfg_setup = 2'b11;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL noop_accept got=%b exp=1", cfg_ready); end
        step();
        checks++; if (dbg_state !== COMMIT || reconfig_done !== 1'b1 || stall_req !== 1'b0 || sweep_valid !== 1'b0 || cfg_ready !== 1'b0)
            begin errors++; $display("FAIL noop_t1 got st=%0d done=%b stall=%b valid=%b ready=%b exp st=3 done=1 stall=0 valid=0 ready=0",
                                     dbg_state, reconfig_done, stall_req, sweep_valid, cfg_ready); end
        step();
        checks++; if (cfg_ready !== 1'b1 || reconfig_done !== 1'b0 || setup !== 2'b11)
            begin errors++; $display("FAIL noop_t2 got ready=%b done=%b setup=%b exp ready=1 done=0 setup=11", cfg_ready, reconfig_done, setup); end
        step();
        checks++; if (reconfig_done !== 1'b1 || stall_req !== 1'b0 || sweep_valid !== 1'b0)
            begin errors++; $display("FAIL noop_b2b got done=%b stall=%b valid=%b exp done=1 stall=0 valid=0", reconfig_done, stall_req, sweep_valid); end
        cfg_valid = 1'b0;
        step();
        checks++; if (dbg_state !== IDLE || reconfig_done !== 1'b0 || setup !== 2'b11)
            begin errors++; $display("FAIL noop_end got st=%0d done=%b setup=%b exp st=0 done=0 setup=11", dbg_state, reconfig_done, setup); end
    endtask

    task automatic test_idle_change();
        issue(2'b01, "chg");
        cfg_setup = 2'b00;
        checks++; if (dbg_state !== DRAIN || stall_req !== 1'b1 || sweep_valid !== 1'b0 || cfg_ready !== 1'b0)
            begin errors++; $display("FAIL chg_drain got st=%0d stall=%b valid=%b ready=%b exp st=1 stall=1 valid=0 ready=0",
                                     dbg_state, stall_req, sweep_valid, cfg_ready); end
        step();
        sweep_and_commit(-1, 0, 2'b11, 2'b01, "chg");
    endtask

    task automatic test_drain();
        cache_busy = 1'b1;
        issue(2'b10, "drain");
        for (int i = 1; i <= 5; i++) begin
            checks++; if (dbg_state !== DRAIN || sweep_valid !== 1'b0 || stall_req !== 1'b1)
                begin errors++; $display("FAIL drain_hold i=%0d got st=%0d valid=%b stall=%b exp st=1 valid=0 stall=1",
                                         i, dbg_state, sweep_valid, stall_req); end
            if (i == 5) cache_busy = 1'b0;
            step();
        end
        sweep_and_commit(-1, 0, 2'b01, 2'b10, "drain");
    endtask

    task automatic test_backpressure();
        issue(2'b00, "bp");
        cache_busy = 1'b1;
        step();
        cache_busy = 1'b0;
        step();
        cache_busy = 1'b1;
        sweep_and_commit(7, 3, 2'b10, 2'b00, "bp");
        cache_busy = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        apply_reset("rst0");
        issue(2'b00, "mid");
        step();
        for (int i = 0; i < 9; i++) step();
        checks++; if (sweep_valid !== 1'b1 || sweep_set !== 4'd9)
            begin errors++; $display("FAIL mid_at9 got valid=%b set=%0d exp valid=1 set=9", sweep_valid, sweep_set); end
        apply_reset("mid");
        checks++; if (setup !== 2'b11 || dbg_state !== IDLE)
            begin errors++; $display("FAIL mid_after got setup=%b st=%0d exp setup=11 st=0", setup, dbg_state); end
        issue(2'b01, "post");
        step();
        sweep_and_commit(-1, 0, 2'b11, 2'b01, "post");
    endtask

    initial begin
        rst_n       = 1'b1;
        cfg_valid   = 1'b0;
        cfg_setup   = 2'b00;
        cache_busy  = 1'b0;
        sweep_ready = 1'b1;
        test_reset();
        test_noop();
        test_idle_change();
        test_drain();
        test_backpressure();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
